// File: rtl/nibble_sort_pkg.sv
// ---------------------------------------------------------------------------
// nibble_sort_pkg
// Shared definitions for the nibble sorter: controller state encoding,
// default batch geometry and the width of the swap counter.
// ---------------------------------------------------------------------------
package nibble_sort_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SORT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int N_ITEMS_DEFAULT = 4;
    localparam int WIDTH_DEFAULT   = 4;

    // Bits needed to count every swap of a worst-case (reversed) batch,
    // which is n*(n-1)/2 swaps.
    function automatic int swap_width(input int n);
        return $clog2(n * (n - 1) / 2 + 1);
    endfunction

endpackage

// File: rtl/nibble_sorter_gt.sv
// ---------------------------------------------------------------------------
// nibble_gt
// The single unsigned magnitude comparator shared by the whole sort.
// Ports:
//   a, b : WIDTH-bit unsigned operands
//   gt   : 1 when a > b (strictly); equal operands give 0
// ---------------------------------------------------------------------------
module nibble_gt #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             gt
);

    assign gt = (a > b);

endmodule

// File: rtl/nibble_sorter.sv
// ---------------------------------------------------------------------------
// nibble_sorter
// Loads N_ITEMS unsigned values, bubble-sorts them in place using one
// comparison per clock through a single shared comparator, then streams
// them out smallest first.
// Ports:
//   clk, rst            : rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready   : load handshake, in_data is the value
//   out_valid/out_ready : drain handshake, out_data is the next sorted value
//   busy                : high while sorting or draining
//   swaps               : swaps performed by the last completed sort
// ---------------------------------------------------------------------------
module nibble_sorter
    import nibble_sort_pkg::*;
#(
    parameter int N_ITEMS = N_ITEMS_DEFAULT,
    parameter int WIDTH   = WIDTH_DEFAULT
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [WIDTH-1:0]                in_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [WIDTH-1:0]                out_data,
    output logic                            busy,
    output logic [swap_width(N_ITEMS)-1:0]  swaps
);

    localparam int IW = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1;
    localparam int SW = swap_width(N_ITEMS);

    localparam logic [IW-1:0] LAST_IDX = IW'(N_ITEMS - 1);
    localparam logic [IW-1:0] LAST_CMP = IW'(N_ITEMS - 2);

    state_t           state;
    logic [WIDTH-1:0] slots [N_ITEMS];
    logic [IW-1:0]    wr_idx;
    logic [IW-1:0]    rd_idx;
    logic [IW-1:0]    cmp_idx;
    logic [IW-1:0]    pass_cnt;
    logic [SW-1:0]    swap_cnt;
    logic             pass_swapped;

    logic [WIDTH-1:0] cmp_a;
    logic [WIDTH-1:0] cmp_b;
    logic             gt;
    logic [SW-1:0]    swap_cnt_next;
    logic             pass_swapped_next;

    // The adjacent pair under test is muxed into the one comparator.
    assign cmp_a = slots[cmp_idx];
    assign cmp_b = slots[cmp_idx + IW'(1)];

    nibble_gt #(.WIDTH(WIDTH)) u_gt (
        .a  (cmp_a),
        .b  (cmp_b),
        .gt (gt)
    );

    // Counter and flag as they stand after this cycle's compare, so the
    // end-of-pass decision and the published count include the last swap.
    assign swap_cnt_next     = swap_cnt + SW'(gt);
    assign pass_swapped_next = pass_swapped | gt;

    // Handshake and status outputs decode the state register only.
    assign in_ready  = (state == LOAD);
    assign out_valid = (state == DRAIN);
    assign busy      = (state != LOAD);
    assign out_data  = slots[rd_idx];

    // NOTE: all state here is updated with non-blocking assignments so the
    // swap below reads both old slot values before either is overwritten.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= LOAD;
            wr_idx       <= '0;
            rd_idx       <= '0;
            cmp_idx      <= '0;
            pass_cnt     <= '0;
            swap_cnt     <= '0;
            pass_swapped <= 1'b0;
            swaps        <= '0;
            // NOTE: the slot array is small and must read as zero after
            // reset, so it is reset like ordinary registers rather than
            // being left to infer a RAM.
            for (int k = 0; k < N_ITEMS; k++) begin
                slots[k] <= '0;
            end
        end else begin
            unique case (state)
                LOAD: begin
                    if (in_valid) begin
                        slots[wr_idx] <= in_data;
                        if (wr_idx == LAST_IDX) begin
                            state        <= SORT;
                            wr_idx       <= '0;
                            cmp_idx      <= '0;
                            pass_cnt     <= '0;
                            swap_cnt     <= '0;
                            pass_swapped <= 1'b0;
                        end else begin
                            wr_idx <= wr_idx + IW'(1);
                        end
                    end
                end

                SORT: begin
                    // Strictly greater only: equal values keep their order.
                    if (gt) begin
                        slots[cmp_idx]          <= cmp_b;
                        slots[cmp_idx + IW'(1)] <= cmp_a;
                    end
                    swap_cnt     <= swap_cnt_next;
                    pass_swapped <= pass_swapped_next;

                    if (cmp_idx == LAST_CMP) begin
                        // A clean pass means sorted; N-1 passes always suffice.
                        if (!pass_swapped_next || pass_cnt == LAST_CMP) begin
                            state  <= DRAIN;
                            swaps  <= swap_cnt_next;
                            rd_idx <= '0;
                        end else begin
                            pass_cnt     <= pass_cnt + IW'(1);
                            cmp_idx      <= '0;
                            pass_swapped <= 1'b0;
                        end
                    end else begin
                        cmp_idx <= cmp_idx + IW'(1);
                    end
                end

                DRAIN: begin
                    if (out_ready) begin
                        if (rd_idx == LAST_IDX) begin
                            state  <= LOAD;
                            rd_idx <= '0;
                            wr_idx <= '0;
                        end else begin
                            rd_idx <= rd_idx + IW'(1);
                        end
                    end
                end

                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_sorter.sv
// ---------------------------------------------------------------------------
// tb_nibble_sorter
// Self-checking bench for nibble_sorter with N_ITEMS=4, WIDTH=4. Expected
// output order comes from a counting sort of each batch pushed into a
// scoreboard queue at load time; a negedge monitor pops and compares every
// output beat and checks that stalled outputs hold steady.
// ---------------------------------------------------------------------------
module tb_nibble_sorter;

    localparam int N  = 4;
    localparam int W  = 4;
    localparam int SW = 3;

    typedef logic [W-1:0] batch_t [N];

    typedef struct {
        batch_t vals;
        int     swaps;
        int     k;
        bit     stall;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_data;
    logic          busy;
    logic [SW-1:0] swaps;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] exp_q [$];
    bit           held = 1'b0;
    logic [W-1:0] held_data = '0;

    vec_t vecs [6];

    always #5 clk = ~clk;

    nibble_sorter #(.N_ITEMS(N), .WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .swaps     (swaps)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Output monitor: every accepted beat is compared against the scoreboard;
    // a beat offered but not taken must reappear unchanged next cycle.
    always @(negedge clk) begin
        if (rst) begin
            held = 1'b0;
        end else begin
            if (held) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_data", 32'(out_data), 32'(held_data));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("unexpected_beat", 32'd1, 32'd0);
                else check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
            end
            held      = out_valid && !out_ready;
            held_data = out_data;
        end
    end

    task automatic set_vec(input int idx, input int a, input int b, input int c, input int d,
                           input int sw, input int k, input bit st);
        vecs[idx].vals[0] = W'(a);
        vecs[idx].vals[1] = W'(b);
        vecs[idx].vals[2] = W'(c);
        vecs[idx].vals[3] = W'(d);
        vecs[idx].swaps   = sw;
        vecs[idx].k       = k;
        vecs[idx].stall   = st;
    endtask

    // Counting sort: emit each value 0..15 as many times as it occurs.
    task automatic push_sorted(input batch_t v);
        for (int x = 0; x < (1 << W); x++)
            for (int i = 0; i < N; i++)
                if (v[i] == W'(x)) exp_q.push_back(W'(x));
    endtask

    // Called #1 after an edge; returns #1 after the edge that took the last beat.
    task automatic load_batch(input batch_t v);
        int n;
        for (int i = 0; i < N; i++) begin
            in_valid = 1'b1;
            in_data  = v[i];
            n = 0;
            while (!in_ready && n < 200) begin
                @(posedge clk); #1;
                n++;
            end
            if (!in_ready) check("load_timeout", 32'd0, 32'd1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_sort(input int exp_k, input bit pulse);
        int n;
        check("busy_in_sort", 32'(busy), 32'd1);
        check("in_ready_in_sort", 32'(in_ready), 32'd0);
        n = 0;
        while (!out_valid && n < 50) begin
            if (pulse) begin
                in_valid = n[0];
                in_data  = W'(9);
                if (in_valid) check("no_accept_sort", 32'(in_ready), 32'd0);
            end
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        check("sort_cycles", 32'(n), 32'(exp_k));
    endtask

    task automatic drain(input int exp_swaps, input bit stall, input bit pulse);
        int c;
        check("swaps_at_drain", 32'(swaps), 32'(exp_swaps));
        c = 0;
        while (!in_ready && c < 100) begin
            out_ready = stall ? (c % 3 == 0) : 1'b1;
            if (pulse) begin
                in_valid = c[0];
                in_data  = W'(9);
            end
            @(posedge clk); #1;
            c++;
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("drain_done", 32'(in_ready), 32'd1);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        check("out_valid_after", 32'(out_valid), 32'd0);
        check("swaps_hold", 32'(swaps), 32'(exp_swaps));
        if (!stall) check("drain_cycles", 32'(c), 32'(N));
    endtask

    task automatic run_vec(input vec_t v);
        push_sorted(v.vals);
        load_batch(v.vals);
        wait_sort(v.k, v.stall);
        drain(v.swaps, v.stall, v.stall);
    endtask

    initial begin
        batch_t b;
        batch_t stream [2];
        int     idx;
        int     run;
        int     cyc;
        bit     acc;
        int     runs [$];

        // {values, swaps (inversion count), sort cycles, stall/pulse}
        set_vec(0,  1,  2,  3,  4, 0, 3, 1'b0);
        set_vec(1,  4,  3,  2,  1, 6, 9, 1'b0);
        set_vec(2,  5,  5,  5,  5, 0, 3, 1'b0);
        set_vec(3,  0, 15,  0, 15, 1, 6, 1'b0);
        set_vec(4,  7,  3,  7,  0, 4, 9, 1'b0);
        set_vec(5, 15,  0,  8,  8, 3, 6, 1'b1);

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_swaps", 32'(swaps), 32'd0);
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Reset two compares into a sort: batch discarded, status cleared.
        b[0] = 4'd4; b[1] = 4'd3; b[2] = 4'd2; b[3] = 4'd1;
        load_batch(b);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("midsort_rst_out_valid", 32'(out_valid), 32'd0);
        check("midsort_rst_swaps", 32'(swaps), 32'd0);
        check("midsort_rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        check("post_rst_out_valid", 32'(out_valid), 32'd0);
        begin
            vec_t v;
            v.vals[0] = 4'd2; v.vals[1] = 4'd1; v.vals[2] = 4'd4; v.vals[3] = 4'd3;
            v.swaps = 2; v.k = 6; v.stall = 1'b0;
            run_vec(v);
        end

        // Back-to-back batches with in_valid and out_ready held high.
        stream[0][0] = 4'd4; stream[0][1] = 4'd3; stream[0][2] = 4'd2; stream[0][3] = 4'd1;
        stream[1][0] = 4'd2; stream[1][1] = 4'd1; stream[1][2] = 4'd4; stream[1][3] = 4'd3;
        push_sorted(stream[0]);
        push_sorted(stream[1]);
        out_ready = 1'b1;
        idx = 0;
        run = 0;
        cyc = 0;
        while ((idx < 2 * N || !in_ready) && cyc < 300) begin
            in_valid = (idx < 2 * N);
            if (idx < 2 * N) in_data = stream[idx / N][idx % N];
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            cyc++;
            if (acc) idx++;
            if (!in_ready) run++;
            else if (run > 0) begin
                runs.push_back(run);
                run = 0;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("b2b_done", 32'(cyc < 300), 32'd1);
        check("b2b_low_runs", 32'(runs.size()), 32'd2);
        if (runs.size() == 2) begin
            check("b2b_low_run0", 32'(runs[0]), 32'd13);
            check("b2b_low_run1", 32'(runs[1]), 32'd10);
        end
        check("b2b_queue_empty", 32'(exp_q.size()), 32'd0);
        check("b2b_swaps", 32'(swaps), 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
